// File: rtl/sum_packer_if.sv
// Stream-in / packed-out bus for sum_packer: serial column sums in, one packed group out.
// master = upstream producer side, slave = sum_packer side.
interface sum_packer_if #(
  parameter int unsigned BitSize     = 8,
  parameter int unsigned NumOfNerves = 4,
  parameter int unsigned OutBitSize  = 8
);
  logic                                   in_valid;
  logic                                   in_start;
  logic [BitSize-1:0]                     in_data;
  logic [NumOfNerves-1:0][BitSize-1:0]    bias;
  logic                                   out_valid;
  logic                                   out_start;
  logic [NumOfNerves-1:0][OutBitSize-1:0] out_data;
  logic                                   out_err;

  modport master (
    output in_valid, in_start, in_data, bias,
    input  out_valid, out_start, out_data, out_err
  );

  modport slave (
    input  in_valid, in_start, in_data, bias,
    output out_valid, out_start, out_data, out_err
  );
endinterface

// File: rtl/sum_packer.sv
// Bias/shift/saturate each serial column sum and pack NumOfNerves results into one output group.
// Optional ReLU after the shift is enabled by defining SUM_PACKER_RELU_EN.
module sum_packer #(
  parameter int unsigned BitSize     = 8,
  parameter int unsigned NumOfNerves = 4,
  parameter int unsigned OutBitSize  = 8,
  parameter int unsigned Shift       = 0,
  parameter int unsigned DepthOut    = 2
) (
  input logic          clk,
  input logic          res,
  sum_packer_if.slave  bus
);

  localparam int unsigned LaneW = (NumOfNerves > 1) ? $clog2(NumOfNerves) : 1;
  localparam int unsigned FrW   = (DepthOut > 1) ? $clog2(DepthOut) : 1;
  localparam int unsigned SumW  = BitSize + 1;
  localparam int unsigned CmpW  = (SumW > OutBitSize) ? SumW : OutBitSize;

  localparam logic signed [CmpW-1:0] OutMax =
    {{(CmpW - OutBitSize + 1){1'b0}}, {(OutBitSize - 1){1'b1}}};
  localparam logic signed [CmpW-1:0] OutMin =
    {{(CmpW - OutBitSize + 1){1'b1}}, {(OutBitSize - 1){1'b0}}};
  localparam logic [LaneW-1:0] LastK    = LaneW'(NumOfNerves - 1);
  localparam logic [FrW-1:0]   LastFrame = FrW'(DepthOut - 1);

  typedef enum logic {StIdle, StFill} state_e;

  state_e                                 state_q, state_d;
  logic [LaneW-1:0]                       slot_q, slot_d;
  logic [FrW-1:0]                         frame_q, frame_d;
  logic [NumOfNerves-1:0][OutBitSize-1:0] fill_q, fill_d;
  logic [NumOfNerves-1:0][OutBitSize-1:0] out_data_q, out_data_d;
  logic                                   out_valid_q, out_valid_d;
  logic                                   out_start_q, out_start_d;
  logic                                   out_err_q, out_err_d;

  logic                   accept, last, complete;
  logic [LaneW-1:0]       k, lane;
  logic [BitSize-1:0]     lane_bias;
  logic signed [SumW-1:0] sum, shifted;
  logic signed [CmpW-1:0] wide;
  logic [OutBitSize-1:0]  lane_val;

  // Per-element datapath: bias add without wrap, arithmetic shift, optional ReLU, saturate.
  always_comb begin
    k         = bus.in_start ? '0 : slot_q;
    lane      = LastK - k;
    lane_bias = bus.bias[lane];
    sum       = {bus.in_data[BitSize-1], bus.in_data} + {lane_bias[BitSize-1], lane_bias};
    shifted   = sum >>> Shift;
`ifdef SUM_PACKER_RELU_EN
    if (shifted[SumW-1]) shifted = '0;
`endif
    wide = CmpW'(shifted);
    if (wide > OutMax) begin
      lane_val = OutMax[OutBitSize-1:0];
    end else if (wide < OutMin) begin
      lane_val = OutMin[OutBitSize-1:0];
    end else begin
      lane_val = wide[OutBitSize-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    frame_d     = frame_q;
    fill_d      = fill_q;
    out_data_d  = out_data_q;
    accept      = bus.in_valid && (bus.in_start || (state_q == StFill));
    last        = (k == LastK);
    complete    = accept && last;
    out_valid_d = complete;
    out_start_d = complete && (frame_q == '0);
    // A start mid-group or a non-start while idle breaks the group framing.
    out_err_d   = bus.in_valid && (bus.in_start ? (state_q == StFill) : (state_q == StIdle));

    if (accept) begin
      fill_d[lane] = lane_val;
      if (last) begin
        state_d = StIdle;
        slot_d  = '0;
      end else begin
        state_d = StFill;
        slot_d  = k + 1'b1;
      end
    end

    if (complete) begin
      out_data_d = fill_d;
      frame_d    = (frame_q == LastFrame) ? '0 : frame_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= StIdle;
      slot_q      <= '0;
      frame_q     <= '0;
      fill_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      frame_q     <= frame_d;
      fill_q      <= fill_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_start_q <= out_start_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_start = out_start_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_sum_packer.sv
// Directed self-checking bench for sum_packer: default instance plus a Shift=2 instance.
module tb_sum_packer;

  logic clk;
  logic res;
  int   checks;
  int   failures;
  int   cyc;

  int          vq[$];
  logic        sq[$];
  logic [31:0] dq[$];
  int          eq[$];

  sum_packer_if #(.BitSize(8), .NumOfNerves(4), .OutBitSize(8)) bus0 ();
  sum_packer_if #(.BitSize(8), .NumOfNerves(4), .OutBitSize(8)) bus1 ();

  sum_packer #(
    .BitSize(8), .NumOfNerves(4), .OutBitSize(8), .Shift(0), .DepthOut(2)
  ) dut0 (
    .clk (clk),
    .res (res),
    .bus (bus0)
  );

  sum_packer #(
    .BitSize(8), .NumOfNerves(4), .OutBitSize(8), .Shift(2), .DepthOut(2)
  ) dut1 (
    .clk (clk),
    .res (res),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every output pulse of dut0 with the cycle it was seen in.
  always @(negedge clk) begin
    if (bus0.out_valid === 1'b1) begin
      vq.push_back(cyc);
      sq.push_back(bus0.out_start);
      dq.push_back(bus0.out_data);
    end
    if (bus0.out_err === 1'b1) eq.push_back(cyc);
  end

  task automatic clear_q();
    vq.delete();
    sq.delete();
    dq.delete();
    eq.delete();
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    bus0.in_valid = v;
    bus0.in_start = s;
    bus0.in_data  = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    res = 1'b1;
    bus0.in_valid = 1'b0;
    bus0.in_start = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.in_start = 1'b0;
    @(negedge clk);
    res = 1'b0;
    clear_q();
  endtask

  task automatic test_reset();
    res = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", bus0.out_valid);
    end
    checks++;
    if (bus0.out_start !== 1'b0) begin
      failures++; $display("FAIL reset_start got=%b exp=0", bus0.out_start);
    end
    checks++;
    if (bus0.out_err !== 1'b0) begin
      failures++; $display("FAIL reset_err got=%b exp=0", bus0.out_err);
    end
    checks++;
    if (bus0.out_data !== 32'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=00000000", bus0.out_data);
    end
    res = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    drive(1'b1, 1'b1, 8'd5);
    drive(1'b1, 1'b0, 8'd6);
    drive(1'b1, 1'b0, 8'd7);
    drive(1'b1, 1'b0, 8'd8);
    drive(1'b0, 1'b0, 8'd0);
    checks++;
    if (bus0.out_valid !== 1'b1) begin
      failures++; $display("FAIL basic_valid got=%b exp=1", bus0.out_valid);
    end
    checks++;
    if (bus0.out_start !== 1'b1) begin
      failures++; $display("FAIL basic_start got=%b exp=1", bus0.out_start);
    end
    checks++;
    if (bus0.out_data !== 32'h05060708) begin
      failures++; $display("FAIL basic_data got=%h exp=05060708", bus0.out_data);
    end
    @(negedge clk);
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      failures++; $display("FAIL basic_pulse got=%b exp=0", bus0.out_valid);
    end
    checks++;
    if (bus0.out_data !== 32'h05060708) begin
      failures++; $display("FAIL basic_hold got=%h exp=05060708", bus0.out_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [12];
    vals = '{8'd1, 8'd2, 8'd3, 8'd4, 8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'd10, 8'd20, 8'd30, 8'd40};
    do_reset();
    for (int i = 0; i < 12; i++) drive(1'b1, (i % 4) == 0, vals[i]);
    drive(1'b0, 1'b0, 8'd0);
    repeat (2) @(negedge clk);
    checks++;
    if (vq.size() != 3) begin
      failures++; $display("FAIL b2b_count got=%0d exp=3", vq.size());
    end else begin
      checks++;
      if (vq[1] - vq[0] != 4) begin
        failures++; $display("FAIL b2b_gap1 got=%0d exp=4", vq[1] - vq[0]);
      end
      checks++;
      if (vq[2] - vq[1] != 4) begin
        failures++; $display("FAIL b2b_gap2 got=%0d exp=4", vq[2] - vq[1]);
      end
      checks++;
      if ({sq[0], sq[1], sq[2]} !== 3'b101) begin
        failures++; $display("FAIL b2b_start got=%b%b%b exp=101", sq[0], sq[1], sq[2]);
      end
      checks++;
      if (dq[1] !== 32'hFFFEFDFC) begin
        failures++; $display("FAIL b2b_data1 got=%h exp=fffefdfc", dq[1]);
      end
      checks++;
      if (dq[2] !== 32'h0A141E28) begin
        failures++; $display("FAIL b2b_data2 got=%h exp=0a141e28", dq[2]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] exp2;
    logic [7:0] exp1;
`ifdef SUM_PACKER_RELU_EN
    exp2 = 8'h00;
    exp1 = 8'h00;
`else
    exp2 = 8'h80;
    exp1 = 8'hFD;
`endif
    do_reset();
    bus0.bias[3] = 8'd100;
    bus0.bias[2] = 8'hFF;
    drive(1'b1, 1'b1, 8'd100);
    drive(1'b1, 1'b0, 8'h80);
    drive(1'b1, 1'b0, 8'hFD);
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 8'd0);
    checks++;
    if (bus0.out_valid !== 1'b1) begin
      failures++; $display("FAIL sat_valid got=%b exp=1", bus0.out_valid);
    end
    checks++;
    if (bus0.out_data !== {8'h7F, exp2, exp1, 8'h00}) begin
      failures++;
      $display("FAIL sat_data got=%h exp=%h", bus0.out_data, {8'h7F, exp2, exp1, 8'h00});
    end
    bus0.bias = '0;
  endtask

  task automatic test_shift();
    logic [7:0] vals [4];
    logic [31:0] exp;
    vals = '{8'd13, 8'hF9, 8'd1, 8'hFF};
`ifdef SUM_PACKER_RELU_EN
    exp = 32'h04000000;
`else
    exp = 32'h04FE00FF;
`endif
    do_reset();
    bus1.bias[3] = 8'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus1.in_valid = 1'b1;
      bus1.in_start = (i == 0);
      bus1.in_data  = vals[i];
    end
    @(negedge clk);
    bus1.in_valid = 1'b0;
    bus1.in_start = 1'b0;
    checks++;
    if (bus1.out_valid !== 1'b1 || bus1.out_start !== 1'b1) begin
      failures++;
      $display("FAIL shift_valid got=%b%b exp=11", bus1.out_valid, bus1.out_start);
    end
    checks++;
    if (bus1.out_data !== exp) begin
      failures++; $display("FAIL shift_data got=%h exp=%h", bus1.out_data, exp);
    end
  endtask

  task automatic test_protocol_err();
    do_reset();
    drive(1'b1, 1'b1, 8'd1);
    drive(1'b1, 1'b0, 8'd2);
    drive(1'b1, 1'b1, 8'd11);
    drive(1'b1, 1'b0, 8'd12);
    drive(1'b1, 1'b0, 8'd13);
    drive(1'b1, 1'b0, 8'd14);
    drive(1'b0, 1'b0, 8'd0);
    repeat (2) @(negedge clk);
    checks++;
    if (eq.size() != 1 || vq.size() != 1) begin
      failures++;
      $display("FAIL restart_counts got=err%0d/valid%0d exp=err1/valid1", eq.size(), vq.size());
    end else begin
      checks++;
      if (vq[0] - eq[0] != 3) begin
        failures++; $display("FAIL restart_timing got=%0d exp=3", vq[0] - eq[0]);
      end
      checks++;
      if (dq[0] !== 32'h0B0C0D0E || sq[0] !== 1'b1) begin
        failures++; $display("FAIL restart_data got=%h/%b exp=0b0c0d0e/1", dq[0], sq[0]);
      end
    end
    clear_q();
    drive(1'b1, 1'b0, 8'd9);
    drive(1'b0, 1'b0, 8'd0);
    repeat (2) @(negedge clk);
    checks++;
    if (eq.size() != 1 || vq.size() != 0) begin
      failures++;
      $display("FAIL idle_err got=err%0d/valid%0d exp=err1/valid0", eq.size(), vq.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 1'b1, 8'd5);
    drive(1'b1, 1'b0, 8'd6);
    drive(1'b1, 1'b0, 8'd7);
    drive(1'b1, 1'b0, 8'd8);
    drive(1'b1, 1'b1, 8'd1);
    drive(1'b1, 1'b0, 8'd2);
    #2;
    res = 1'b1;
    #1;
    checks++;
    if (bus0.out_data !== 32'h0) begin
      failures++; $display("FAIL async_data got=%h exp=00000000", bus0.out_data);
    end
    checks++;
    if (bus0.out_valid !== 1'b0 || bus0.out_start !== 1'b0 || bus0.out_err !== 1'b0) begin
      failures++;
      $display("FAIL async_ctrl got=%b%b%b exp=000", bus0.out_valid, bus0.out_start,
               bus0.out_err);
    end
    bus0.in_valid = 1'b0;
    @(negedge clk);
    res = 1'b0;
    clear_q();
    drive(1'b1, 1'b0, 8'd3);
    drive(1'b1, 1'b0, 8'd4);
    drive(1'b0, 1'b0, 8'd0);
    @(negedge clk);
    clear_q();
    drive(1'b1, 1'b1, 8'd21);
    drive(1'b1, 1'b0, 8'd22);
    drive(1'b1, 1'b0, 8'd23);
    drive(1'b1, 1'b0, 8'd24);
    drive(1'b0, 1'b0, 8'd0);
    repeat (2) @(negedge clk);
    checks++;
    if (vq.size() != 1) begin
      failures++; $display("FAIL async_count got=%0d exp=1", vq.size());
    end else begin
      checks++;
      if (dq[0] !== 32'h15161718 || sq[0] !== 1'b1) begin
        failures++; $display("FAIL async_group got=%h/%b exp=15161718/1", dq[0], sq[0]);
      end
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    cyc           = 0;
    res           = 1'b1;
    bus0.in_valid = 1'b0;
    bus0.in_start = 1'b0;
    bus0.in_data  = '0;
    bus0.bias     = '0;
    bus1.in_valid = 1'b0;
    bus1.in_start = 1'b0;
    bus1.in_data  = '0;
    bus1.bias     = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturate();
    test_shift();
    test_protocol_err();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
